// File: rtl/des_io_sequencer.sv
// Pad-side byte sequencer for the DES core: synchronises the slow I/O strobe, assembles
// 64-bit key/text words, runs the core with a timeout and streams the result out MSB first.
module des_io_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        io_clk_i,
  input  logic [7:0]  io_in_byte,
  input  logic        io_in_valid,
  input  logic        io_in_sel,
  output logic [7:0]  io_out_byte,
  output logic        io_out_valid,
  output logic [7:0]  io_out_oeb,
  output logic [63:0] core_key,
  output logic [63:0] core_text,
  output logic        core_start,
  input  logic        core_done,
  input  logic [63:0] core_result,
  output logic        busy,
  output logic        key_loaded,
  output logic        err_timeout,
  output logic [2:0]  fsm_state
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_EMIT  = 3'd4
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] clk_sync, vld_sync, sel_sync;
  logic [7:0]             byte_sync [SYNC_STAGES];
  logic                   clk_prev;
  logic                   tick, s_valid, s_sel;
  logic [7:0]             s_byte;

  logic [63:0]   key_reg, text_reg, out_reg;
  logic [3:0]    cnt;
  logic          cur_sel;
  logic [TW-1:0] timer;
  logic [2:0]    idx;
  logic [63:0]   out_shift;

  logic cap, fresh, key_done, tmr_clr, tmr_inc, tmo, latch, idx_inc;

  // All pad inputs share the same chain depth so the byte/valid/sel seen at tick
  // are the values the host held stable around the io_clk rise.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      clk_sync <= '0;
      vld_sync <= '0;
      sel_sync <= '0;
      clk_prev <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) byte_sync[i] <= '0;
    end else begin
      clk_sync     <= {clk_sync[SYNC_STAGES-2:0], io_clk_i};
      vld_sync     <= {vld_sync[SYNC_STAGES-2:0], io_in_valid};
      sel_sync     <= {sel_sync[SYNC_STAGES-2:0], io_in_sel};
      clk_prev     <= clk_sync[SYNC_STAGES-1];
      byte_sync[0] <= io_in_byte;
      for (int i = 1; i < SYNC_STAGES; i++) byte_sync[i] <= byte_sync[i-1];
    end
  end

  assign tick    = clk_sync[SYNC_STAGES-1] & ~clk_prev;
  assign s_valid = vld_sync[SYNC_STAGES-1];
  assign s_sel   = sel_sync[SYNC_STAGES-1];
  assign s_byte  = byte_sync[SYNC_STAGES-1];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    cap        = 1'b0;
    fresh      = 1'b0;
    key_done   = 1'b0;
    tmr_clr    = 1'b0;
    tmr_inc    = 1'b0;
    tmo        = 1'b0;
    latch      = 1'b0;
    idx_inc    = 1'b0;
    case (state)
      S_IDLE: begin
        if (tick && s_valid) begin
          cap        = 1'b1;
          fresh      = 1'b1;
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (tick && s_valid) begin
          cap = 1'b1;
          // A select flip abandons the partial word's count but not its register contents.
          if (s_sel != cur_sel) begin
            fresh = 1'b1;
          end else if (cnt == 4'd7) begin
            if (cur_sel) begin
              state_next = S_START;
            end else begin
              key_done   = 1'b1;
              state_next = S_IDLE;
            end
          end
        end
      end
      S_START: begin
        tmr_clr    = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          latch      = 1'b1;
          state_next = S_EMIT;
        end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          tmo        = 1'b1;
          state_next = S_IDLE;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      S_EMIT: begin
        if (tick) begin
          if (idx == 3'd7) state_next = S_IDLE;
          else             idx_inc    = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      key_reg     <= '0;
      text_reg    <= '0;
      out_reg     <= '0;
      cnt         <= '0;
      cur_sel     <= 1'b0;
      timer       <= '0;
      idx         <= '0;
      key_loaded  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (cap) begin
        if (s_sel) text_reg <= {text_reg[55:0], s_byte};
        else       key_reg  <= {key_reg[55:0], s_byte};
      end
      if (fresh)    cnt <= 4'd1;
      else if (cap) cnt <= cnt + 4'd1;
      if (fresh) cur_sel <= s_sel;
      if (key_done)              key_loaded <= 1'b1;
      else if (cap && !s_sel)    key_loaded <= 1'b0;
      if (tmr_clr)      timer <= '0;
      else if (tmr_inc) timer <= timer + 1'b1;
      if (tmo) err_timeout <= 1'b1;
      if (latch) out_reg <= core_result;
      if (latch)        idx <= '0;
      else if (idx_inc) idx <= idx + 3'd1;
    end
  end

  assign out_shift    = out_reg << {idx, 3'b000};
  assign io_out_valid = (state == S_EMIT);
  assign io_out_oeb   = (state == S_EMIT) ? 8'h00 : 8'hFF;
  assign io_out_byte  = (state == S_EMIT) ? out_shift[63:56] : 8'h00;
  assign core_start   = (state == S_START);
  assign busy         = (state == S_START) || (state == S_WAIT) || (state == S_EMIT);
  assign core_key     = key_reg;
  assign core_text    = text_reg;
  assign fsm_state    = state;

endmodule

// File: tb/tb_des_io_sequencer.sv
// Directed bench for des_io_sequencer: pad byte strobes, a behavioural DES core
// with programmable latency/hang, and a byte scoreboard on the output stream.
module tb_des_io_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        io_clk = 1'b0;
  logic [7:0]  io_in_byte = '0;
  logic        io_in_valid = 1'b0;
  logic        io_in_sel = 1'b0;
  logic [7:0]  io_out_byte;
  logic        io_out_valid;
  logic [7:0]  io_out_oeb;
  logic [63:0] core_key, core_text;
  logic        core_start;
  logic        core_done = 1'b0;
  logic [63:0] core_result = '0;
  logic        busy, key_loaded, err_timeout;
  logic [2:0]  fsm_state;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [63:0] exp_key = '0;
  logic [63:0] exp_text = '0;

  // core model controls and observations
  int cyc = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int err_cyc = 0;
  int done_wait = 0;
  int core_delay = 16;
  bit core_hang = 1'b0;
  bit lat_seen = 1'b0;
  bit err_seen = 1'b0;
  logic lat_valid = 1'b0;
  logic [63:0] model_res = '0;

  des_io_sequencer #(.TIMEOUT_CYCLES(64), .SYNC_STAGES(2)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .io_clk_i(io_clk),
    .io_in_byte(io_in_byte), .io_in_valid(io_in_valid), .io_in_sel(io_in_sel),
    .io_out_byte(io_out_byte), .io_out_valid(io_out_valid), .io_out_oeb(io_out_oeb),
    .core_key(core_key), .core_text(core_text), .core_start(core_start),
    .core_done(core_done), .core_result(core_result),
    .busy(busy), .key_loaded(key_loaded), .err_timeout(err_timeout),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // Behavioural core, evaluated on the falling edge so the DUT sees stable inputs.
  always @(negedge clk) begin
    cyc++;
    if (core_done) begin
      lat_valid = io_out_valid;
      lat_seen  = 1'b1;
      core_done = 1'b0;
    end
    if (rst) begin
      done_wait = 0;
    end else if (core_start) begin
      start_cnt++;
      start_cyc = cyc;
      done_wait = core_hang ? 0 : core_delay;
    end else if (done_wait > 0) begin
      done_wait--;
      if (done_wait == 0) begin
        core_done   = 1'b1;
        core_result = model_res;
      end
    end
    if (err_timeout && !err_seen) begin
      err_seen = 1'b1;
      err_cyc  = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic io_pulse(input logic v, input logic s, input logic [7:0] b);
    @(negedge clk);
    io_in_byte  = b;
    io_in_valid = v;
    io_in_sel   = s;
    repeat ($urandom_range(2, 4)) @(negedge clk);
    io_clk = 1'b1;
    repeat ($urandom_range(6, 9)) @(negedge clk);
    io_clk = 1'b0;
    repeat ($urandom_range(4, 6)) @(negedge clk);
    io_in_valid = 1'b0;
  endtask

  task automatic load(input logic s, input logic [7:0] b);
    io_pulse(1'b1, s, b);
    if (s) exp_text = {exp_text[55:0], b};
    else   exp_key  = {exp_key[55:0], b};
  endtask

  task automatic load_word(input logic s, input logic [63:0] w);
    logic [63:0] t;
    t = w;
    for (int i = 0; i < 8; i++) begin
      load(s, t[63:56]);
      t = t << 8;
    end
  endtask

  task automatic push_result(input logic [63:0] r);
    logic [63:0] t;
    t = r;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(t[63:56]);
      t = t << 8;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!lat_seen && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(lat_seen), 64'd1);
    chk("first_byte_latency", 64'(lat_valid), 64'd1);
  endtask

  // Each emitted byte is compared, then a tick is sent with junk valid data that must be ignored.
  task automatic drain(input int n);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      chk("out_valid", 64'(io_out_valid), 64'd1);
      chk("out_oeb", 64'(io_out_oeb), 64'h00);
      chk("out_byte", 64'(io_out_byte), 64'(e));
      io_pulse(1'b1, 1'b1, 8'hAA);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_oeb", 64'(io_out_oeb), 64'hFF);
    chk("rst_valid", 64'(io_out_valid), 64'd0);
    chk("rst_byte", 64'(io_out_byte), 64'd0);
    chk("rst_key_loaded", 64'(key_loaded), 64'd0);
    chk("rst_err", 64'(err_timeout), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_start", 64'(core_start), 64'd0);
    chk("rst_key", core_key, 64'd0);
    chk("rst_text", core_text, 64'd0);
    chk("rst_state", 64'(fsm_state), 64'd0);

    // key then text, core answers after 16 cycles
    load_word(1'b0, 64'h133457799BBCDFF1);
    chk("key_loaded_set", 64'(key_loaded), 64'd1);
    chk("core_key_val", core_key, 64'h133457799BBCDFF1);
    chk("core_key_model", core_key, exp_key);
    chk("no_start_after_key", 64'(start_cnt), 64'd0);
    model_res  = 64'h85E813540F0AB405;
    core_delay = 16;
    lat_seen   = 1'b0;
    push_result(model_res);
    load_word(1'b1, 64'h0123456789ABCDEF);
    wait_done();
    chk("core_text_val", core_text, 64'h0123456789ABCDEF);
    chk("start_once", 64'(start_cnt), 64'd1);
    chk("busy_emit", 64'(busy), 64'd1);
    drain(8);
    chk("post_oeb", 64'(io_out_oeb), 64'hFF);
    chk("post_valid", 64'(io_out_valid), 64'd0);
    chk("post_byte", 64'(io_out_byte), 64'd0);
    chk("post_state", 64'(fsm_state), 64'd0);
    chk("text_kept_emit", core_text, 64'h0123456789ABCDEF);
    chk("start_once_post", 64'(start_cnt), 64'd1);
    chk("q_empty_1", 64'(exp_q.size()), 64'd0);

    // select flip discards partial text count; then a hung core times out
    load(1'b1, 8'h11);
    load(1'b1, 8'h22);
    load(1'b1, 8'h33);
    load(1'b0, 8'h44);
    chk("flip_key_loaded_clr", 64'(key_loaded), 64'd0);
    chk("flip_key", core_key, exp_key);
    chk("flip_text", core_text, exp_text);
    chk("flip_no_start", 64'(start_cnt), 64'd1);
    core_hang = 1'b1;
    load(1'b1, 8'hF0);
    load(1'b1, 8'hE1);
    load(1'b1, 8'hD2);
    load(1'b1, 8'hC3);
    load(1'b1, 8'hB4);
    load(1'b1, 8'hA5);
    load(1'b1, 8'h96);
    chk("seven_no_start", 64'(start_cnt), 64'd1);
    chk("seven_busy", 64'(busy), 64'd0);
    load(1'b1, 8'h87);
    chk("eighth_start", 64'(start_cnt), 64'd2);
    chk("eighth_text", core_text, 64'hF0E1D2C3B4A59687);
    n = 0;
    while (!err_seen && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_seen", 64'(err_seen), 64'd1);
    chk("timeout_cycles", 64'(err_cyc - start_cyc), 64'd65);
    chk("timeout_idle", 64'(fsm_state), 64'd0);
    chk("timeout_busy", 64'(busy), 64'd0);

    // recovery run with junk valid strobe during WAIT
    core_hang  = 1'b0;
    core_delay = 40;
    model_res  = 64'hA5C30F1E77889912;
    lat_seen   = 1'b0;
    push_result(model_res);
    load_word(1'b1, 64'h0F1E2D3C4B5A6978);
    chk("rec_start", 64'(start_cnt), 64'd3);
    io_pulse(1'b1, 1'b1, 8'h5A);
    chk("wait_text_kept", core_text, 64'h0F1E2D3C4B5A6978);
    chk("wait_no_extra_start", 64'(start_cnt), 64'd3);
    wait_done();
    drain(8);
    chk("rec_idle", 64'(fsm_state), 64'd0);
    chk("err_sticky", 64'(err_timeout), 64'd1);
    chk("rec_start_total", 64'(start_cnt), 64'd3);

    // reset during the fourth output byte
    load_word(1'b0, 64'h0011223344556677);
    chk("reload_key_loaded", 64'(key_loaded), 64'd1);
    core_delay = 10;
    model_res  = 64'hDEADBEEFCAFEF00D;
    lat_seen   = 1'b0;
    push_result(model_res);
    load_word(1'b1, 64'h8899AABBCCDDEEFF);
    wait_done();
    drain(3);
    chk("emit_byte3", 64'(io_out_byte), 64'(exp_q[0]));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_oeb", 64'(io_out_oeb), 64'hFF);
    chk("arst_valid", 64'(io_out_valid), 64'd0);
    chk("arst_key_loaded", 64'(key_loaded), 64'd0);
    chk("arst_err", 64'(err_timeout), 64'd0);
    chk("arst_state", 64'(fsm_state), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/des_io_sequencer.md
Name: des_io_sequencer

Overview:
Controller between the byte-wide user I/O pads and the 64-bit DES core in the user project area. It synchronises the slow external I/O clock into the Wishbone clock domain. It assembles 8-byte key and text words from the pad input bus, starts the core and waits for completion. It then streams the 64-bit result back out on the pad output bus, one byte per I/O clock edge, most-significant byte first.

Parameters:
TIMEOUT_CYCLES, 1024, max wb_clk_i cycles to wait for core_done before aborting
SYNC_STAGES, 2, flip-flop depth of each pad-input synchroniser (minimum 2)

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  asynchronous reset, active-high
io_clk_i  in  1  external byte strobe from pad; asynchronous to wb_clk_i
io_in_byte  in  8  pad input byte
io_in_valid  in  1  pad input byte valid
io_in_sel  in  1  word select: 0 = key byte, 1 = text byte
io_out_byte  out  8  pad output byte
io_out_valid  out  1  output byte valid
io_out_oeb  out  8  pad output enables, active-low
core_key  out  64  key to DES core
core_text  out  64  text block to DES core
core_start  out  1  one-cycle start pulse
core_done  in  1  core completion pulse, level-sampled
core_result  in  64  core output, valid when core_done=1
busy  out  1  high in any state other than IDLE/LOAD
key_loaded  out  1  a full 8-byte key has been captured
err_timeout  out  1  sticky; the core failed to finish within TIMEOUT_CYCLES

Behaviour:
- Synchronisation:
  - io_clk_i, io_in_valid, io_in_sel and io_in_byte each pass through a SYNC_STAGES flop chain.
  - tick = one-cycle pulse on a synchronised io_clk rising edge.
  - All pad sampling happens only on tick.
  - The host holds the byte, valid and sel inputs stable from before the io_clk rise until the io_clk fall.
- Reset values:
  - All outputs 0, except io_out_oeb = 8'hFF.
  - Byte counters 0, state IDLE.
  - err_timeout is cleared only by reset.
- Load rule: on tick with valid=1, shift the byte into the word selected by sel. Each word is shifted left by 8, with the new byte in [7:0], so the first byte ends up as MSB.
- FSM states:
  - IDLE: on tick & valid, capture the byte, cnt=1, latch cur_sel, go to LOAD.
  - LOAD, tick & valid & sel==cur_sel: capture the byte, cnt++.
  - LOAD, tick & valid & sel!=cur_sel: discard the partial word's count. The new byte starts a fresh word with cnt=1 and cur_sel=sel. The word register being abandoned keeps its shifted contents.
  - LOAD, cnt reaches 8 with cur_sel=0: key_loaded=1, go to IDLE.
  - LOAD, cnt reaches 8 with cur_sel=1: go to START.
  - LOAD, tick with valid=0: no change.
  - START: core_start=1 for exactly one cycle, timer=0, go to WAIT. The block starts regardless of key_loaded; an unloaded key is 0.
  - WAIT, core_done=1: latch core_result into out_reg, idx=0, go to EMIT.
  - WAIT, timer reaches TIMEOUT_CYCLES-1 without done: set err_timeout, go to IDLE.
  - EMIT: io_out_oeb=0, io_out_valid=1, io_out_byte=out_reg[63-8*idx -: 8]. Each tick increments idx. The tick while idx==7 releases the bus (oeb=FF, valid=0, byte=0) and goes to IDLE.
- Inputs are ignored in START, WAIT and EMIT. Ticks arriving then are not buffered.
- core_key and core_text are driven continuously from the word registers. They do not change in START, WAIT or EMIT.
- A new key load after key_loaded=1 clears key_loaded on its first byte. key_loaded sets again after 8 bytes.
- Asynchronous reset mid-operation returns everything to its reset values immediately. This includes releasing the bus.
- Latencies:
  - core_start asserts 1 cycle after the tick that captures the 8th text byte.
  - The first output byte appears 1 cycle after core_done.

Test Plan:
- Key 13 34 57 79 9B BC DF F1 (sel=0), then text 01 23 45 67 89 AB CD EF (sel=1) -> core_key=133457799BBCDFF1 and core_text=0123456789ABCDEF. key_loaded=1 after the 8th key byte. Exactly one core_start pulse.
- Core model returns 85E813540F0AB405 after 16 cycles -> io_out_byte sequence 85 E8 13 54 0F 0A B4 05, one byte per io_clk rise. oeb=00 during the stream, FF afterwards, and the FSM returns to IDLE.
- Three text bytes, then a key byte (sel flip) -> the text count is discarded. The key count becomes 1. No core_start until 8 further contiguous text bytes.
- Core model never asserts done, TIMEOUT_CYCLES=64 -> err_timeout=1 after 64 cycles in WAIT. State returns to IDLE, and the next load works normally.
- io_in_valid toggled while in WAIT and EMIT -> core_text unchanged and no extra start.
- wb_rst_i asserted during EMIT byte 3 -> immediately oeb=FF, valid=0, key_loaded=0, err_timeout=0.
